// File: rtl/pokey_bus_master.sv
`timescale 1ns/1ps
// pokey_bus_master: replays queued host register commands as POKEY bus
// cycles paced by the phi2 enable, with an IDLE -> ACCESS -> RECOVER sequence.
// Optional read-back path (read cycles, response capture) is built only when
// POKEY_BUS_READBACK_EN is defined; otherwise reads are dropped without a cycle.
module pokey_bus_master #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] BZ_BASE    = 16'h1820,
  parameter logic [15:0] RB_BASE    = 16'h1810
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_3MHz_en,
  input  logic        mod_redbaron,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [3:0]  cmd_reg,
  input  logic [7:0]  cmd_data,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_data,
  output logic        bus_should_read,
  output logic        bus_active,
  input  logic [7:0]  bus_din,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        busy
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic       write;
    logic [3:0] reg_idx;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  cmd_t          fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          active_q, active_d;
  logic          push, pop, empty, full, start;
  cmd_t          head;

`ifdef POKEY_BUS_READBACK_EN
  logic          rd_q, rd_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
`else
  logic          unused_din;
  assign unused_din = ^bus_din;
`endif

  // FIFO bookkeeping plus bus-sequencing FSM next state; base address is
  // latched at the IDLE strobe so mod_redbaron cannot disturb a cycle in flight.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(FIFO_DEPTH));
    push     = cmd_valid && !full;
    head     = fifo_mem[rd_ptr_q];
    pop      = 1'b0;
    start    = 1'b0;
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    active_d = active_q;
`ifdef POKEY_BUS_READBACK_EN
    rd_d        = rd_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
`endif
    case (state_q)
      IDLE: begin
        if (clk_3MHz_en && !empty) begin
          pop = 1'b1;
`ifdef POKEY_BUS_READBACK_EN
          start = 1'b1;
`else
          start = head.write;
`endif
          if (start) begin
            state_d  = ACCESS;
            addr_d   = (mod_redbaron ? RB_BASE : BZ_BASE) + {12'h0, head.reg_idx};
            data_d   = head.write ? head.data : '0;
            active_d = 1'b1;
`ifdef POKEY_BUS_READBACK_EN
            rd_d     = !head.write;
`endif
          end
        end
      end
      ACCESS: begin
        if (clk_3MHz_en) begin
`ifdef POKEY_BUS_READBACK_EN
          if (rd_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = bus_din;
          end
          rd_d = 1'b0;
`endif
          addr_d   = '0;
          data_d   = '0;
          active_d = 1'b0;
          state_d  = RECOVER;
        end
      end
      RECOVER: begin
        if (clk_3MHz_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // State, pointer and bus-output registers; reset idles the bus at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      active_q    <= 1'b0;
`ifdef POKEY_BUS_READBACK_EN
      rd_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      active_q    <= active_d;
`ifdef POKEY_BUS_READBACK_EN
      rd_q        <= rd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`endif
    end
  end

  // Command storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {cmd_write, cmd_reg, cmd_data};
  end

  assign cmd_ready  = !full;
  assign busy       = !empty || (state_q != IDLE);
  assign bus_addr   = addr_q;
  assign bus_data   = data_q;
  assign bus_active = active_q;
`ifdef POKEY_BUS_READBACK_EN
  assign bus_should_read = rd_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
`else
  assign bus_should_read = 1'b0;
  assign rsp_valid       = 1'b0;
  assign rsp_data        = '0;
`endif

endmodule

// File: tb/tb_pokey_bus_master.sv
`timescale 1ns/1ps
// Scoreboard bench for pokey_bus_master: expected bus cycles and read
// responses are queued as commands are issued and checked by a monitor.
module tb_pokey_bus_master;

  logic        clk = 1'b0, rst = 1'b0, clk_3MHz_en = 1'b0, mod_redbaron = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [3:0]  cmd_reg = '0;
  logic [7:0]  cmd_data = '0, bus_din = '0;
  logic        cmd_ready, bus_should_read, bus_active, rsp_valid, busy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data, rsp_data;

  int vectors = 0, miscompares = 0;
  int n_access = 0;
  logic strobe_on = 1'b0, gap_check = 1'b0, have_prev = 1'b0;
  int phase = 0;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rd;
  } acc_t;
  acc_t       exp_bus[$];
  logic [7:0] exp_rsp[$];

  pokey_bus_master #(.FIFO_DEPTH(8), .BZ_BASE(16'h1820), .RB_BASE(16'h1810)) dut (
    .clk(clk), .rst(rst), .clk_3MHz_en(clk_3MHz_en), .mod_redbaron(mod_redbaron),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_reg(cmd_reg), .cmd_data(cmd_data), .bus_addr(bus_addr), .bus_data(bus_data),
    .bus_should_read(bus_should_read), .bus_active(bus_active), .bus_din(bus_din),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  // phi2 strobe: one clk in four, first strobe right after enabling
  initial forever begin
    @(negedge clk);
    if (strobe_on) begin
      clk_3MHz_en = (phase == 0);
      phase = (phase + 1) % 4;
    end else begin
      clk_3MHz_en = 1'b0;
      phase = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] exp_addr(input logic m, input logic [3:0] r);
    return (m ? 16'h1810 : 16'h1820) + {12'h0, r};
  endfunction

  // Monitor: pops scoreboard on each bus cycle start and each response pulse
  initial begin : mon
    logic prev_act, prev_rsp, held_err;
    int act_str, idle_str;
    logic [15:0] cur_addr;
    acc_t e;
    logic [7:0] d;
    prev_act = 1'b0; prev_rsp = 1'b0; held_err = 1'b0;
    act_str = 0; idle_str = 0; cur_addr = '0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        prev_act = 1'b0;
        prev_rsp = 1'b0;
      end else begin
        if (bus_active && !prev_act) begin
          n_access++;
          vectors++;
          if (exp_bus.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_access: got addr %h rd %b, required no cycle", bus_addr, bus_should_read);
          end else begin
            e = exp_bus.pop_front();
            if (bus_addr !== e.addr || bus_should_read !== e.rd || (!e.rd && bus_data !== e.data)) begin
              miscompares++;
              $display("FAIL access: got addr %h data %h rd %b, required addr %h data %h rd %b",
                       bus_addr, bus_data, bus_should_read, e.addr, e.data, e.rd);
            end
          end
          if (gap_check && have_prev) begin
            vectors++;
            if (idle_str != 2) begin
              miscompares++;
              $display("FAIL idle_gap: got %0d idle strobes, required 2", idle_str);
            end
          end
          have_prev = 1'b1;
          cur_addr  = bus_addr;
          held_err  = 1'b0;
          act_str   = 0;
        end else if (bus_active && bus_addr !== cur_addr) begin
          held_err = 1'b1;
        end
        if (!bus_active && prev_act) begin
          vectors++;
          if (act_str != 1 || held_err) begin
            miscompares++;
            $display("FAIL access_hold: got %0d strobes held_err %b, required 1 strobe held_err 0", act_str, held_err);
          end
          idle_str = 0;
        end
        if (clk_3MHz_en) begin
          if (bus_active) act_str++;
          else idle_str++;
        end
        if (rsp_valid) begin
          vectors++;
          if (prev_rsp) begin
            miscompares++;
            $display("FAIL rsp_width: got rsp_valid high 2+ clks, required 1");
          end else if (exp_rsp.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_rsp: got rsp_data %h, required no response", rsp_data);
          end else begin
            d = exp_rsp.pop_front();
            if (rsp_data !== d) begin
              miscompares++;
              $display("FAIL rsp_data: got %h, required %h", rsp_data, d);
            end
          end
        end
        prev_act = bus_active;
        prev_rsp = rsp_valid;
      end
    end
  end

  // Drive one command for one clk (valid left high); record expectations
  task automatic issue(input logic w, input logic [3:0] r, input logic [7:0] dat,
                       input logic expect_it, output logic accepted);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_reg = r; cmd_data = dat;
    accepted = cmd_ready;
    if (accepted && expect_it) begin
      if (w) exp_bus.push_back('{addr: exp_addr(mod_redbaron, r), data: dat, rd: 1'b0});
`ifdef POKEY_BUS_READBACK_EN
      else begin
        exp_bus.push_back('{addr: exp_addr(mod_redbaron, r), data: 8'h00, rd: 1'b1});
        exp_rsp.push_back(bus_din);
      end
`endif
    end
  endtask

  task automatic release_cmd();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_clks);
    for (int i = 0; i < max_clks; i++) begin
      @(negedge clk); #2;
      if (exp_bus.size() == 0 && exp_rsp.size() == 0 && !busy) break;
    end
    vectors++;
    if (exp_bus.size() != 0 || exp_rsp.size() != 0 || busy) begin
      miscompares++;
      $display("FAIL drain: got %0d bus / %0d rsp pending busy %b, required 0/0/0",
               exp_bus.size(), exp_rsp.size(), busy);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #2;
    vectors++;
    if ({cmd_ready, busy, bus_active, bus_should_read, rsp_valid, bus_addr, bus_data, rsp_data}
        !== {1'b1, 4'b0, 16'h0, 8'h0, 8'h0}) begin
      miscompares++;
      $display("FAIL reset_async: got rdy %b busy %b act %b addr %h rsp %b, required 1 0 0 0000 0",
               cmd_ready, busy, bus_active, bus_addr, rsp_valid);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if ({cmd_ready, busy, bus_active, bus_addr, rsp_valid} !== {1'b1, 2'b0, 16'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_clocked: got rdy %b busy %b act %b addr %h, required 1 0 0 0000", cmd_ready, busy, bus_active, bus_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_write();
    logic acc;
    mod_redbaron = 1'b0;
    issue(1'b1, 4'h8, 8'hA5, 1'b1, acc);
    release_cmd();
    @(posedge clk); #1;
    vectors++;
    if (bus_active !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL frozen_no_strobe: got act %b busy %b, required 0 1", bus_active, busy);
    end
    strobe_on = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({bus_active, bus_should_read, bus_addr, bus_data} !== {2'b10, 16'h1828, 8'hA5}) begin
      miscompares++;
      $display("FAIL write_start: got act %b rd %b addr %h data %h, required 1 0 1828 a5",
               bus_active, bus_should_read, bus_addr, bus_data);
    end
    mod_redbaron = 1'b1;
    wait_drain(40);
    mod_redbaron = 1'b0;
    vectors++;
    if ({bus_active, bus_addr, bus_data} !== 25'h0) begin
      miscompares++;
      $display("FAIL write_idle: got act %b addr %h data %h, required 0 0000 00", bus_active, bus_addr, bus_data);
    end
    strobe_on = 1'b0;
  endtask

`ifdef POKEY_BUS_READBACK_EN
  task automatic test_read();
    logic acc;
    mod_redbaron = 1'b1;
    bus_din = 8'h5C;
    issue(1'b0, 4'hA, 8'hFF, 1'b1, acc);
    release_cmd();
    strobe_on = 1'b1;
    wait_drain(40);
    strobe_on = 1'b0;
    bus_din = 8'h00;
    vectors++;
    if (rsp_data !== 8'h5C) begin
      miscompares++;
      $display("FAIL rsp_hold: got %h, required 5c", rsp_data);
    end
    mod_redbaron = 1'b0;
  endtask
`endif

  task automatic test_read_then_write();
    logic acc;
    mod_redbaron = 1'b0;
    bus_din = 8'h96;
    issue(1'b0, 4'h1, 8'h00, 1'b1, acc);
    issue(1'b1, 4'h1, 8'h3C, 1'b1, acc);
    release_cmd();
    strobe_on = 1'b1;
    wait_drain(60);
    strobe_on = 1'b0;
`ifndef POKEY_BUS_READBACK_EN
    vectors++;
    if (rsp_data !== 8'h00 || bus_should_read !== 1'b0) begin
      miscompares++;
      $display("FAIL no_readback: got rsp_data %h rd %b, required 00 0", rsp_data, bus_should_read);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic acc;
    int n_acc;
    n_acc = 0;
    mod_redbaron = 1'b0;
    for (int i = 0; i < 9; i++) begin
      issue(1'b1, 4'(i + 3), 8'(8'h40 + i), 1'b1, acc);
      if (acc) n_acc++;
    end
    vectors++;
    if (n_acc != 8 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL fifo_full: got %0d accepted rdy %b busy %b, required 8 0 1", n_acc, cmd_ready, busy);
    end
    release_cmd();
    repeat (5) @(negedge clk);
    vectors++;
    if (bus_active !== 1'b0 || cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL frozen_full: got act %b rdy %b, required 0 0", bus_active, cmd_ready);
    end
    have_prev = 1'b0;
    gap_check = 1'b1;
    strobe_on = 1'b1;
    wait_drain(200);
    strobe_on = 1'b0;
    gap_check = 1'b0;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_drain: got %b, required 1", cmd_ready);
    end
  endtask

  task automatic test_reset_mid_access();
    logic acc;
    int base;
    mod_redbaron = 1'b0;
    bus_din = 8'hE7;
`ifdef POKEY_BUS_READBACK_EN
    issue(1'b0, 4'h2, 8'h00, 1'b0, acc);
    exp_bus.push_back('{addr: 16'h1822, data: 8'h00, rd: 1'b1});
`else
    issue(1'b1, 4'h2, 8'h77, 1'b0, acc);
    exp_bus.push_back('{addr: 16'h1822, data: 8'h77, rd: 1'b0});
`endif
    for (int i = 0; i < 3; i++) issue(1'b1, 4'(i + 5), 8'(8'h20 + i), 1'b0, acc);
    release_cmd();
    strobe_on = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #2;
      if (bus_active) break;
    end
    vectors++;
    if (bus_active !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_start: got act %b, required 1", bus_active);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({bus_active, bus_should_read, rsp_valid, busy, cmd_ready, bus_addr, bus_data} !== {4'b0, 1'b1, 16'h0, 8'h0}) begin
      miscompares++;
      $display("FAIL mid_reset: got act %b rsp %b busy %b rdy %b addr %h, required 0 0 0 1 0000",
               bus_active, rsp_valid, busy, cmd_ready, bus_addr);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    base = n_access;
    repeat (40) @(negedge clk);
    #2;
    vectors++;
    if (n_access != base || busy !== 1'b0 || exp_bus.size() != 0) begin
      miscompares++;
      $display("FAIL post_reset: got %0d new cycles busy %b pending %0d, required 0 0 0",
               n_access - base, busy, exp_bus.size());
    end
    strobe_on = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
`ifdef POKEY_BUS_READBACK_EN
    test_read();
`endif
    test_read_then_write();
    test_back_to_back();
    test_reset_mid_access();
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
